// File: rtl/pairing_host_loader_pkg.sv
// Shared types and constants for the BN254 pairing host loader.
// DATA_W matches one redundant_poly_L3 word; ADDR_W covers the core RAM depth.
package pairing_host_loader_pkg;

  localparam int DATA_W = 304;
  localparam int ADDR_W = 9;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    KICK,
    WAIT,
    DRAIN,
    DONE
  } host_state_e;

  // Base plus offset into the core RAM, wrapping modulo the RAM size.
  function automatic logic [ADDR_W-1:0] wrap_addr(input int base,
                                                  input logic [ADDR_W-1:0] off);
    return ADDR_W'(base) + off;
  endfunction

endpackage

// File: rtl/pairing_host_loader_if.sv
// External RAM / control port of the BN254 pairing core.
// master: host sequencer side, slave: pairing core side.
interface pairing_host_loader_if;
  import pairing_host_loader_pkg::*;

  logic              core_run;
  logic [3:0]        core_n_func;
  logic              core_swrst;
  logic              core_busy;
  logic              core_endflag;
  logic              core_we;
  logic [ADDR_W-1:0] core_waddr;
  logic [DATA_W-1:0] core_wdata;
  logic [ADDR_W-1:0] core_raddr;
  logic [DATA_W-1:0] core_rdata;

  modport master (
    output core_run, core_n_func, core_swrst, core_we, core_waddr, core_wdata, core_raddr,
    input  core_busy, core_endflag, core_rdata
  );

  modport slave (
    input  core_run, core_n_func, core_swrst, core_we, core_waddr, core_wdata, core_raddr,
    output core_busy, core_endflag, core_rdata
  );

endinterface

// File: rtl/pairing_host_loader_out_fifo.sv
// host_out_fifo: small first-word-fall-through buffer for result words.
// DEPTH must be a power of two so the pointers wrap naturally.
module host_out_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 304
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/pairing_host_loader.sv
// pairing_host_loader: loads operands into the pairing core RAM, kicks the core,
// waits for completion and streams the results back out with backpressure.
// Optional feature macro: PAIRING_HOST_TIMEOUT_EN (WAIT timeout, err_timeout, core_swrst).
module pairing_host_loader
  import pairing_host_loader_pkg::*;
#(
  parameter int N_IN      = 24,
  parameter int N_OUT     = 12,
  parameter int LOAD_BASE = 0,
  parameter int OUT_BASE  = 256,
  parameter int RD_LAT    = 2,
  parameter int FIFO_D    = 4,
  parameter int TMO_W     = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        func,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  pairing_host_loader_if.master core
);

  localparam int CNT_W  = ADDR_W + 1;
  localparam int FCNT_W = $clog2(FIFO_D) + 1;
  localparam int OCC_W  = FCNT_W + $clog2(RD_LAT + 1) + 1;

  localparam logic [CNT_W-1:0] LAST_IN   = CNT_W'(N_IN - 1);
  localparam logic [CNT_W-1:0] LAST_OUT  = CNT_W'(N_OUT - 1);
  localparam logic [CNT_W-1:0] N_OUT_C   = CNT_W'(N_OUT);
  localparam logic [OCC_W-1:0] FIFO_D_C  = OCC_W'(FIFO_D);

  host_state_e       state, state_next;
  logic [3:0]        func_q;
  logic [CNT_W-1:0]  wcnt, rcnt, pcnt;
  logic              busy_seen;
  logic [RD_LAT-1:0] rd_pipe;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [FCNT_W-1:0] fifo_count;
  logic [OCC_W-1:0]  inflight;
  logic [OCC_W-1:0]  occupancy;
  logic              in_hs, pop, push, issue, wait_exit, tmo_hit;

  assign in_hs     = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign push      = rd_pipe[RD_LAT-1];
  assign wait_exit = core.core_endflag | (busy_seen & ~core.core_busy);
  assign occupancy = OCC_W'(fifo_count) + inflight;
  assign issue     = (state == DRAIN) && (rcnt < N_OUT_C) && (occupancy < FIFO_D_C);

  // Number of reads still travelling through the core's read pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + OCC_W'(rd_pipe[i]);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    if (in_hs && wcnt == LAST_IN) state_next = KICK;
      KICK:    state_next = WAIT;
      WAIT: begin
        if (wait_exit)    state_next = DRAIN;
        else if (tmo_hit) state_next = DONE;
      end
      DRAIN:   if (pop && pcnt == LAST_OUT) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Job counters, RAM write register and read-pipeline tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      func_q    <= '0;
      wcnt      <= '0;
      rcnt      <= '0;
      pcnt      <= '0;
      busy_seen <= 1'b0;
      rd_pipe   <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      we_q    <= 1'b0;
      rd_pipe <= (rd_pipe << 1) | RD_LAT'(issue);
      case (state)
        IDLE: if (start) begin
          func_q <= func;
          wcnt   <= '0;
          rcnt   <= '0;
          pcnt   <= '0;
        end
        LOAD: if (in_hs) begin
          we_q    <= 1'b1;
          waddr_q <= wrap_addr(LOAD_BASE, wcnt[ADDR_W-1:0]);
          wdata_q <= in_data;
          wcnt    <= wcnt + 1'b1;
        end
        KICK:  busy_seen <= 1'b0;
        WAIT:  if (core.core_busy) busy_seen <= 1'b1;
        DRAIN: begin
          if (issue) rcnt <= rcnt + 1'b1;
          if (pop)   pcnt <= pcnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef PAIRING_HOST_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q;

  // Cycles spent in WAIT for the current job.
  always_ff @(posedge clk) begin
    if (rst)                tmo_cnt <= '0;
    else if (state == WAIT) tmo_cnt <= tmo_cnt + 1'b1;
    else                    tmo_cnt <= '0;
  end

  // Sticky timeout flag, cleared only when a new job is accepted.
  always_ff @(posedge clk) begin
    if (rst)                                  err_q <= 1'b0;
    else if (state == IDLE && start)          err_q <= 1'b0;
    else if (tmo_hit && !wait_exit)           err_q <= 1'b1;
  end

  assign tmo_hit         = (state == WAIT) && (tmo_cnt == '1);
  assign core.core_swrst = tmo_hit & ~wait_exit;
  assign err_timeout     = err_q;
`else
  assign tmo_hit         = 1'b0;
  assign core.core_swrst = 1'b0;
  assign err_timeout     = 1'b0;
`endif

  host_out_fifo #(
    .DEPTH (FIFO_D),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (core.core_rdata),
    .pop       (pop),
    .head      (out_data),
    .count     (fifo_count)
  );

  assign out_valid        = (fifo_count != '0);
  assign in_ready         = (state == LOAD);
  assign busy             = (state != IDLE);
  assign done             = (state == DONE);
  assign core.core_run    = (state == KICK);
  assign core.core_n_func = func_q;
  assign core.core_we     = we_q;
  assign core.core_waddr  = waddr_q;
  assign core.core_wdata  = wdata_q;
  assign core.core_raddr  = wrap_addr(OUT_BASE, rcnt[ADDR_W-1:0]);

endmodule

// File: tb/tb_pairing_host_loader.sv
// Self-checking bench for pairing_host_loader with a stub pairing core.
// Jobs come from a table; writes and result words are checked against scoreboard queues.
module tb_pairing_host_loader;
  import pairing_host_loader_pkg::*;

  localparam int N_IN      = 24;
  localparam int N_OUT     = 12;
  localparam int LOAD_BASE = 0;
  localparam int OUT_BASE  = 256;
  localparam int FIFO_D    = 4;

  typedef struct {
    logic [3:0] func;
    int         mode;
    int         delay;
    int         ready_mode;
    bit         in_gap;
    bit         start_in_load;
    int         exp_words;
    bit         exp_timeout;
  } job_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [3:0]        func = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              busy, done, err_timeout;

  pairing_host_loader_if core_if();

  pairing_host_loader #(.TMO_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .func        (func),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done),
    .err_timeout (err_timeout),
    .core        (core_if)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cycle = 0;

  always @(posedge clk) cycle <= cycle + 1;

  // Stub core: RAM read returns its address RD_LAT=2 cycles later.
  logic [ADDR_W-1:0] ra1, ra2;
  always @(posedge clk) begin
    ra1 <= core_if.core_raddr;
    ra2 <= ra1;
  end
  assign core_if.core_rdata = DATA_W'(ra2);

  int stub_mode = 0;
  int stub_delay = 10;
  int stub_cnt = 0;
  bit stub_active = 1'b0;

  // Stub core completion: endflag pulse, busy window or never finishing.
  always @(posedge clk) begin
    core_if.core_endflag <= 1'b0;
    if (rst || core_if.core_swrst) begin
      stub_active       <= 1'b0;
      core_if.core_busy <= 1'b0;
    end else if (core_if.core_run) begin
      stub_active <= 1'b1;
      stub_cnt    <= 1;
      if (stub_mode == 1) core_if.core_busy <= 1'b1;
    end else if (stub_active) begin
      stub_cnt <= stub_cnt + 1;
      if (stub_cnt == stub_delay - 1 && stub_mode != 2) begin
        if (stub_mode == 0) core_if.core_endflag <= 1'b1;
        core_if.core_busy <= 1'b0;
        stub_active       <= 1'b0;
      end
    end
  end

  logic [ADDR_W+DATA_W-1:0] wexp_q[$];
  logic [DATA_W-1:0]        oexp_q[$];
  logic [ADDR_W+DATA_W-1:0] wexp_e;
  logic [DATA_W-1:0]        oexp_e;

  int we_cnt, run_cnt, done_cnt, word_cnt, swrst_cnt, ovalid_cnt, max_fifo;
  int last_pop_cycle, run_cycle, swrst_cycle, cur_exp_words;
  logic [3:0] run_func;

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                             input logic [DATA_W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL %s: event not observed within its bound", name);
  endtask

  // Monitor: scoreboard compares on core writes and output handshakes.
  always @(negedge clk) begin
    if (!rst) begin
      if (core_if.core_we) begin
        we_cnt++;
        if (wexp_q.size() == 0) failNow("unexpected_write");
        else begin
          wexp_e = wexp_q.pop_front();
          checkOutput("waddr", DATA_W'(core_if.core_waddr), DATA_W'(wexp_e[ADDR_W+DATA_W-1:DATA_W]));
          checkOutput("wdata", core_if.core_wdata, wexp_e[DATA_W-1:0]);
        end
      end
      if (core_if.core_run) begin
        run_cnt++;
        run_func  = core_if.core_n_func;
        run_cycle = cycle;
      end
      if (core_if.core_swrst) begin
        swrst_cnt++;
        swrst_cycle = cycle;
      end
      if (out_valid) ovalid_cnt++;
      if (out_valid && out_ready) begin
        word_cnt++;
        last_pop_cycle = cycle;
        if (oexp_q.size() == 0) failNow("unexpected_word");
        else begin
          oexp_e = oexp_q.pop_front();
          checkOutput("out_data", out_data, oexp_e);
        end
      end
      if (done) begin
        done_cnt++;
        if (cur_exp_words > 0) checkOutput("done_after_last_word", DATA_W'(cycle), DATA_W'(last_pop_cycle + 1));
      end
      if (int'(dut.fifo_count) > max_fifo) max_fifo = int'(dut.fifo_count);
    end
  end

  function automatic logic [DATA_W-1:0] randWord();
    logic [DATA_W-1:0] w = '0;
    for (int i = 0; i < 10; i++) w = (w << 32) | DATA_W'($urandom);
    return w;
  endfunction

  task automatic clearCounters();
    we_cnt = 0; run_cnt = 0; done_cnt = 0; word_cnt = 0; swrst_cnt = 0;
    ovalid_cnt = 0; max_fifo = 0; last_pop_cycle = -10; run_cycle = 0; swrst_cycle = 0;
    run_func = 'x;
  endtask

  // Start a job and feed its operand words, queueing the expected writes.
  task automatic startAndLoad(input job_t j);
    int k = 0;
    int guard = 0;
    clearCounters();
    cur_exp_words = j.exp_words;
    stub_mode     = j.mode;
    stub_delay    = j.delay;
    for (int i = 0; i < j.exp_words; i++) oexp_q.push_back(DATA_W'(OUT_BASE + i));
    @(posedge clk); #1;
    start = 1'b1;
    func  = j.func;
    @(posedge clk); #1;
    start = 1'b0;
    while (k < N_IN && guard < 200) begin
      in_valid = !(j.in_gap && (guard % 3 == 2));
      in_data  = randWord();
      start    = j.start_in_load && (k == 10);
      if (start) func = ~j.func;
      @(negedge clk);
      if (in_valid && in_ready) begin
        wexp_q.push_back({ADDR_W'(LOAD_BASE + k), in_data});
        k++;
      end
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (k != N_IN) failNow("load_incomplete");
  endtask

  task automatic applyStimulus(input job_t j);
    int c = 0;
    bit seen = 1'b0;
    startAndLoad(j);
    while (!seen && c < 3000) begin
      @(posedge clk); #1;
      out_ready = (j.ready_mode == 0) ? 1'b1 : ((c % 3) == 0);
      @(negedge clk);
      if (done) seen = 1'b1;
      c++;
    end
    if (!seen) failNow("done_timeout");
    @(posedge clk); #1;
    out_ready = 1'b1;
  endtask

  task automatic checkJob(input job_t j);
    checkOutput("we_pulses", DATA_W'(we_cnt), DATA_W'(N_IN));
    checkOutput("run_pulses", DATA_W'(run_cnt), DATA_W'(1));
    checkOutput("run_func", DATA_W'(run_func), DATA_W'(j.func));
    checkOutput("done_pulses", DATA_W'(done_cnt), DATA_W'(1));
    checkOutput("words", DATA_W'(word_cnt), DATA_W'(j.exp_words));
    checkOutput("words_left", DATA_W'(oexp_q.size()), DATA_W'(0));
    checkOutput("fifo_within_depth", DATA_W'(max_fifo <= FIFO_D), DATA_W'(1));
    checkOutput("busy_after_job", DATA_W'(busy), DATA_W'(0));
    checkOutput("err_timeout", DATA_W'(err_timeout), DATA_W'(j.exp_timeout));
    if (j.exp_timeout) begin
      checkOutput("swrst_pulses", DATA_W'(swrst_cnt), DATA_W'(1));
      checkOutput("swrst_at_wait_255", DATA_W'(swrst_cycle - run_cycle), DATA_W'(256));
      checkOutput("no_out_valid", DATA_W'(ovalid_cnt), DATA_W'(0));
    end else begin
      checkOutput("swrst_pulses", DATA_W'(swrst_cnt), DATA_W'(0));
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  job_t jobs[$];

  initial begin
    job_t rj;
    int g;
    jobs.push_back('{4'h3, 0, 100, 0, 1'b0, 1'b0, N_OUT, 1'b0});
    jobs.push_back('{4'h7, 0, 20,  1, 1'b1, 1'b0, N_OUT, 1'b0});
    jobs.push_back('{4'hA, 1, 30,  0, 1'b0, 1'b1, N_OUT, 1'b0});
    jobs.push_back('{4'h5, 0, 5,   1, 1'b0, 1'b1, N_OUT, 1'b0});
`ifdef PAIRING_HOST_TIMEOUT_EN
    jobs.push_back('{4'h9, 2, 0,   0, 1'b0, 1'b0, 0,     1'b1});
`endif
    clearCounters();
    cur_exp_words = 0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_in_ready", DATA_W'(in_ready), DATA_W'(0));
    checkOutput("reset_out_valid", DATA_W'(out_valid), DATA_W'(0));
    checkOutput("reset_busy", DATA_W'(busy), DATA_W'(0));
    checkOutput("reset_done", DATA_W'(done), DATA_W'(0));
    checkOutput("reset_err_timeout", DATA_W'(err_timeout), DATA_W'(0));
    checkOutput("reset_core_run", DATA_W'(core_if.core_run), DATA_W'(0));
    checkOutput("reset_core_swrst", DATA_W'(core_if.core_swrst), DATA_W'(0));
    checkOutput("reset_core_we", DATA_W'(core_if.core_we), DATA_W'(0));

    foreach (jobs[i]) begin
      $display("[TB] job %0d func=%0h mode=%0d", i, jobs[i].func, jobs[i].mode);
      applyStimulus(jobs[i]);
      checkJob(jobs[i]);
    end

    // Reset in the middle of DRAIN after five result words.
    rj = '{4'hC, 0, 8, 0, 1'b0, 1'b0, N_OUT, 1'b0};
    startAndLoad(rj);
    g = 0;
    while (word_cnt < 5 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (word_cnt < 5) failNow("rst_test_words");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_drain_busy", DATA_W'(busy), DATA_W'(0));
    checkOutput("rst_mid_drain_out_valid", DATA_W'(out_valid), DATA_W'(0));
    checkOutput("rst_mid_drain_in_ready", DATA_W'(in_ready), DATA_W'(0));
    checkOutput("rst_mid_drain_swrst", DATA_W'(swrst_cnt), DATA_W'(0));
    oexp_q.delete();
    wexp_q.delete();
    rj.func = 4'h6;
    applyStimulus(rj);
    checkJob(rj);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
